// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary converter: counts ones over a 2^CNT_W-1 sample window and
// presents the count behind valid/ready. Define SC_BIPOLAR_EN to add the signed result_bp output.
module sc_stream_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_bit,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             valid,
  input  logic             ready
`ifdef SC_BIPOLAR_EN
  ,
  output logic [CNT_W:0]   result_bp
`endif
);

  localparam logic [CNT_W-1:0] WIN      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IDX = WIN - {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] sum_s;

  assign sum_s = acc_q + {{(CNT_W-1){1'b0}}, in_bit};

`ifdef SC_BIPOLAR_EN
  logic [CNT_W:0] bp_q, bp_d;
  logic [CNT_W:0] bp_s;

  // 2*count - WIN wraps modulo 2^(CNT_W+1), which is exactly its two's-complement form
  assign bp_s = {sum_s, 1'b0} - {1'b0, WIN};
`endif

  // Next-state, counters and registered output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
`ifdef SC_BIPOLAR_EN
    bp_d     = bp_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COUNT;
          cnt_d   = {CNT_W{1'b0}};
          acc_d   = {CNT_W{1'b0}};
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end else begin
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end
      end
      S_COUNT: begin
        acc_d = sum_s;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_IDX) begin
          state_d  = S_HOLD;
          result_d = sum_s;
          busy_d   = 1'b0;
          valid_d  = 1'b1;
`ifdef SC_BIPOLAR_EN
          bp_d     = bp_s;
`endif
        end else begin
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b1;
        end
        busy_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {CNT_W{1'b0}};
      result_q <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

`ifdef SC_BIPOLAR_EN
  // Bipolar result register, loaded alongside result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_q <= {(CNT_W+1){1'b0}};
    end else begin
      bp_q <= bp_d;
    end
  end

  assign result_bp = bp_q;
`endif

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: doc/sc_stream_counter.md
# sc_stream_counter

Stochastic-to-binary converter that sits directly downstream of the LFSR stochastic number generator. It consumes one stochastic bit per cycle over a fixed window of 2^CNT_W−1 cycles and counts the ones. It then presents the count as a binary value behind a valid/ready handshake. The window length equals the period of the 8-bit maximal LFSR at the default parameter, so one window covers exactly one full LFSR period.

## Interface
Parameters:
- CNT_W, default 8: count width; window length WIN = 2^CNT_W − 1 samples (255 at default); legal range 2..16.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  begin a conversion window; accepted only in IDLE.
- in_bit  in  1  stochastic bitstream from the upstream SNG.
- busy  out  1  high in COUNT state.
- result  out  CNT_W  number of ones in the last window; valid when valid=1.
- valid  out  1  result available.
- ready  in  1  downstream accepts result when valid && ready.
- result_bp  out  CNT_W+1  signed bipolar value; present only with SC_BIPOLAR_EN.

## Operation
- States: IDLE, COUNT, HOLD; reset state IDLE.
- IDLE: busy=0, valid=0. start=1 at an edge → COUNT, with sample counter and ones accumulator cleared to 0.
- COUNT: busy=1. Each edge samples in_bit, accumulator += in_bit, and sample counter += 1.
  - On the edge taking sample WIN, result <= accumulator + in_bit and state → HOLD.
- HOLD: valid=1, busy=0, result held stable. Edge with ready=1 → IDLE (valid drops next cycle).
- start is ignored in COUNT and HOLD, including the HOLD handshake cycle; there is no queuing.
- in_bit and ready are don't-care outside COUNT and HOLD respectively.
- Arithmetic: accumulator is CNT_W bits and cannot overflow because max = WIN = 2^CNT_W − 1; no saturation logic.
- Reset (rst=0) at any time, including mid-COUNT or in HOLD:
  - immediately forces IDLE, busy=0, valid=0, result=0, accumulator=0, sample counter=0;
  - any partial window is discarded.
- Reset values: busy=0, valid=0, result=0, result_bp=0 (when present).

## Timing
- start sampled high at edge t0; in_bit sampled at edges t1..tWIN (exactly WIN samples).
- result/valid registered at tWIN; visible after tWIN.
- Start-to-valid latency: WIN cycles.
- Handshake completes at the first edge with valid=1 and ready=1. ready held high through tWIN gives a single-cycle valid pulse.
- Minimum start-to-start period: WIN+2 cycles (count, one HOLD cycle, one IDLE cycle).
- busy falls and valid rises on the same edge (tWIN).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SC_BIPOLAR_EN defined:
  - adds output result_bp = 2·count − WIN as a two's-complement CNT_W+1-bit value;
  - registered on the same edge as result and held with it; range −WIN..+WIN.
- SC_BIPOLAR_EN undefined:
  - port and its logic are absent;
  - unipolar result only, with identical timing.

## Test plan
- Reset then in_bit=1 constantly, start pulse, ready=1 → valid exactly 255 cycles after start edge, result=255, one-cycle valid.
- in_bit=0 constantly → result=0; then in_bit alternating 1,0,… beginning with 1 on t1 → result=128.
- Backpressure: ready=0 for 20 cycles after valid, with start pulses during HOLD → result stable, valid stays 1, starts ignored. ready=1 → IDLE next cycle, then a new start is accepted.
- start pulses during COUNT → ignored; window length still 255 and count unaffected.
- rst=0 asserted mid-COUNT (sample 100) → busy=0, valid=0, result=0 immediately. Fresh run with all ones → result=255.
- With SC_BIPOLAR_EN, CNT_W=4 (WIN=15):
  - all ones → result=15, result_bp=+15;
  - all zeros → result_bp=−15;
  - alternating starting with 1 → result=8, result_bp=+1.
